// File: rtl/ser_mer_monitor.sv
// Symbol-error / squared-error monitor that finds the tx->rx symbol latency, then measures SER/MER.
// Optional feature macro: SER_SQ_ERR_EN builds the err_in^2 multiplier and sq_err_sum accumulator.
module ser_mer_monitor #(
    parameter int unsigned BPS          = 2,
    parameter int unsigned MAX_DELAY    = 15,
    parameter int unsigned ALIGN_WIN    = 64,
    parameter int unsigned ALIGN_THRESH = 2,
    parameter int unsigned WIN_LOG2     = 20,
    parameter int unsigned EW           = 18,
    localparam int unsigned DW = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1,
    localparam int unsigned CW = WIN_LOG2 + 1,
    localparam int unsigned SW = 2 * EW + WIN_LOG2 - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sym_clk_en,
    input  logic                 start,
    input  logic [BPS-1:0]       tx_sym,
    input  logic [BPS-1:0]       rx_sym,
    input  logic signed [EW-1:0] err_in,
    output logic [1:0]           state,
    output logic [DW-1:0]        delay_sel,
    output logic                 locked,
    output logic                 align_fail,
    output logic                 sym_correct,
    output logic                 sym_error,
    output logic                 meas_done,
    output logic [CW-1:0]        err_count,
    output logic [SW-1:0]        sq_err_sum
);

    localparam int unsigned ACW = $clog2(ALIGN_WIN + 1);
    localparam int unsigned SCW = (ACW > CW) ? ACW : CW;
    localparam logic [SCW-1:0] ALIGN_LAST = SCW'(ALIGN_WIN - 1);
    localparam logic [SCW-1:0] MEAS_LAST  = SCW'((64'd1 << WIN_LOG2) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_MEAS  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         st;
    logic [SCW-1:0] sym_cnt;
    logic [ACW-1:0] miss_cnt;
    logic [ACW-1:0] miss_next;
    logic           fin;
    logic           mismatch;
    logic [BPS-1:0] tap [MAX_DELAY+1];

    // Transmit history; runs in every state so a delay change needs no refill.
    always_ff @(posedge clk) begin
        if (sym_clk_en) begin
            tap[0] <= tx_sym;
            for (int k = 1; k <= int'(MAX_DELAY); k++) begin
                tap[k] <= tap[k-1];
            end
        end
    end

    assign mismatch  = (tap[delay_sel] != rx_sym);
    assign miss_next = miss_cnt + ACW'(mismatch);
    assign state     = st;

    // Control FSM with its counters and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= S_IDLE;
            delay_sel   <= '0;
            locked      <= 1'b0;
            align_fail  <= 1'b0;
            sym_correct <= 1'b0;
            sym_error   <= 1'b0;
            meas_done   <= 1'b0;
            err_count   <= '0;
            sym_cnt     <= '0;
            miss_cnt    <= '0;
            fin         <= 1'b0;
        end else begin
            sym_correct <= 1'b0;
            sym_error   <= 1'b0;
            meas_done   <= 1'b0;
            case (st)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        delay_sel  <= '0;
                        locked     <= 1'b0;
                        align_fail <= 1'b0;
                        err_count  <= '0;
                        sym_cnt    <= '0;
                        miss_cnt   <= '0;
                        fin        <= 1'b0;
                        st         <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (sym_clk_en) begin
                        sym_correct <= ~mismatch;
                        sym_error   <= mismatch;
                        if (sym_cnt == ALIGN_LAST) begin
                            sym_cnt  <= '0;
                            miss_cnt <= '0;
                            if (32'(miss_next) <= ALIGN_THRESH) begin
                                locked <= 1'b1;
                                st     <= S_MEAS;
                            end else if (32'(delay_sel) == MAX_DELAY) begin
                                align_fail <= 1'b1;
                                st         <= S_DONE;
                            end else begin
                                delay_sel <= delay_sel + DW'(1);
                            end
                        end else begin
                            sym_cnt  <= sym_cnt + SCW'(1);
                            miss_cnt <= miss_next;
                        end
                    end
                end
                S_MEAS: begin
                    // fin delays meas_done one clk past the final accumulate
                    if (fin) begin
                        fin       <= 1'b0;
                        meas_done <= 1'b1;
                        st        <= S_DONE;
                    end else if (sym_clk_en) begin
                        sym_correct <= ~mismatch;
                        sym_error   <= mismatch;
                        err_count   <= err_count + CW'(mismatch);
                        sym_cnt     <= sym_cnt + SCW'(1);
                        if (sym_cnt == MEAS_LAST) begin
                            fin <= 1'b1;
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

`ifdef SER_SQ_ERR_EN
    logic signed [2*EW-1:0] sq_prod;
    logic [SW-1:0]          sq_acc;

    // Square is never negative, so its bit pattern is the unsigned magnitude.
    assign sq_prod = err_in * err_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            sq_acc <= '0;
        end else if ((st == S_IDLE || st == S_DONE) && start) begin
            sq_acc <= '0;
        end else if (st == S_MEAS && !fin && sym_clk_en) begin
            sq_acc <= sq_acc + SW'($unsigned(sq_prod));
        end
    end

    assign sq_err_sum = sq_acc;
`else
    logic unused_err_in;

    assign unused_err_in = ^err_in;
    assign sq_err_sum    = '0;
`endif

endmodule

// File: tb/tb_ser_mer_monitor.sv
// Randomised bench for ser_mer_monitor: history-based reference model checked every clk.
module tb_ser_mer_monitor;

    localparam int unsigned BPS          = 2;
    localparam int unsigned MAX_DELAY    = 15;
    localparam int unsigned ALIGN_WIN    = 64;
    localparam int unsigned ALIGN_THRESH = 2;
    localparam int unsigned WIN_LOG2     = 8;
    localparam int unsigned EW           = 18;
    localparam int unsigned DW           = 4;
    localparam int unsigned CW           = WIN_LOG2 + 1;
    localparam int unsigned SW           = 2 * EW + WIN_LOG2 - 1;
    localparam int          MEAS_LEN     = 1 << WIN_LOG2;
    localparam int          HIST         = 16384;
`ifdef SER_SQ_ERR_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sym_clk_en;
    logic                 start;
    logic [BPS-1:0]       tx_sym;
    logic [BPS-1:0]       rx_sym;
    logic signed [EW-1:0] err_in;
    logic [1:0]           state;
    logic [DW-1:0]        delay_sel;
    logic                 locked;
    logic                 align_fail;
    logic                 sym_correct;
    logic                 sym_error;
    logic                 meas_done;
    logic [CW-1:0]        err_count;
    logic [SW-1:0]        sq_err_sum;

    ser_mer_monitor #(
        .BPS(BPS), .MAX_DELAY(MAX_DELAY), .ALIGN_WIN(ALIGN_WIN),
        .ALIGN_THRESH(ALIGN_THRESH), .WIN_LOG2(WIN_LOG2), .EW(EW)
    ) dut (
        .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .start(start),
        .tx_sym(tx_sym), .rx_sym(rx_sym), .err_in(err_in),
        .state(state), .delay_sel(delay_sel), .locked(locked), .align_fail(align_fail),
        .sym_correct(sym_correct), .sym_error(sym_error), .meas_done(meas_done),
        .err_count(err_count), .sq_err_sum(sq_err_sum)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int done_cnt;
    int serr_cnt;

    // Reference model state: full per-enable history of tx, rx and err_in.
    int     txh [HIST];
    int     rxh [HIST];
    int     eh  [HIST];
    int     n_en = 0;
    int     m_state = 0;
    int     m_delay = 0;
    bit     m_locked, m_fail, m_cor, m_err, m_done, m_fin, m_msym;
    int     win_start, meas_start;
    longint m_errc = 0;
    longint m_sq = 0;

    int rx_mode, err_mode;
    bit inv_on;
    int tx_q [$];

    // Symbol n is wrong at delay d when rx differs from tx sent d+1 enables earlier.
    function automatic bit mis(input int n, input int d);
        if (n - 1 - d < 0) return 1'b1;
        return txh[n-1-d] != rxh[n];
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int cur;
        int tot;
        bit en;
        cur = n_en;
        en  = sym_clk_en;
        if (en) begin
            txh[cur] = int'(tx_sym);
            rxh[cur] = int'(rx_sym);
            eh[cur]  = int'(err_in);
            n_en++;
        end
        m_cor = 1'b0; m_err = 1'b0; m_done = 1'b0; m_msym = 1'b0;
        if (reset) begin
            m_state = 0; m_delay = 0; m_locked = 1'b0; m_fail = 1'b0;
            m_fin = 1'b0; m_errc = 0; m_sq = 0;
        end else if (m_state == 0 || m_state == 3) begin
            if (start) begin
                m_state = 1; m_delay = 0; m_locked = 1'b0; m_fail = 1'b0;
                m_fin = 1'b0; m_errc = 0; m_sq = 0; win_start = n_en;
            end
        end else if (m_state == 1) begin
            if (en) begin
                m_err = mis(cur, m_delay);
                m_cor = !m_err;
                if (cur - win_start + 1 == int'(ALIGN_WIN)) begin
                    tot = 0;
                    for (int i = win_start; i <= cur; i++) tot += int'(mis(i, m_delay));
                    if (tot <= int'(ALIGN_THRESH)) begin
                        m_locked = 1'b1; m_state = 2; meas_start = n_en;
                    end else if (m_delay == int'(MAX_DELAY)) begin
                        m_fail = 1'b1; m_state = 3;
                    end else begin
                        m_delay++; win_start = n_en;
                    end
                end
            end
        end else begin
            if (m_fin) begin
                m_fin = 1'b0; m_done = 1'b1; m_state = 3;
            end else if (en) begin
                m_err = mis(cur, m_delay);
                m_cor = !m_err;
                m_msym = 1'b1;
                m_errc = 0; m_sq = 0;
                for (int i = meas_start; i <= cur; i++) begin
                    m_errc += longint'(mis(i, m_delay));
                    if (SQ_EN) m_sq += longint'(eh[i]) * longint'(eh[i]);
                end
                if (cur - meas_start + 1 == MEAS_LEN) m_fin = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", longint'(state), longint'(m_state));
            chk("delay_sel", longint'(delay_sel), longint'(m_delay));
            chk("locked", longint'(locked), longint'(m_locked));
            chk("align_fail", longint'(align_fail), longint'(m_fail));
            chk("sym_correct", longint'(sym_correct), longint'(m_cor));
            chk("sym_error", longint'(sym_error), longint'(m_err));
            chk("meas_done", longint'(meas_done), longint'(m_done));
            chk("err_count", longint'(err_count), m_errc);
            chk("sq_err_sum", longint'(sq_err_sum), m_sq);
            if (meas_done) done_cnt++;
            if (sym_error && m_msym) serr_cnt++;
        end
    end

    task automatic clk1(input bit en, input bit st);
        int k;
        int r;
        sym_clk_en = en;
        start      = st;
        if (en) begin
            tx_sym = BPS'($urandom);
            if (rx_mode == 0 && tx_q.size() >= 6) rx_sym = BPS'(tx_q[tx_q.size()-6]);
            else rx_sym = '0;
            if (inv_on && m_state == 2 && !m_fin) begin
                k = n_en - meas_start + 1;
                if (k == 10 || k == 77 || k == 200) rx_sym = ~rx_sym;
            end
            if (err_mode == 0) err_in = '0;
            else if (err_mode == 1) err_in = EW'(-3);
            else if ($urandom_range(15) == 0) err_in = {1'b1, {(EW-1){1'b0}}};
            else begin
                r = int'($urandom_range(200)) - 100;
                err_in = EW'(r);
            end
            tx_q.push_back(int'(tx_sym));
        end
        @(posedge clk);
        #1;
        sym_clk_en = 1'b0;
        start      = 1'b0;
    endtask

    task automatic sym();
        clk1(1'b1, 1'b0);
        repeat (3) clk1(1'b0, 1'b0);
    endtask

    // hook 1: reset after MEAS symbol 100; hook 2: start pulse after MEAS symbol 50.
    task automatic run_test(input string nm, input int rxm, input int errm, input bit inv,
                            input bit start_with_en, input int hook, input int exp_delay,
                            input bit exp_lock, input bit exp_fail, input int exp_errc,
                            input int exp_done, input int exp_serr, input longint exp_sq);
        int  k;
        bit  aborted;
        bit  hooked;
        rx_mode = rxm; err_mode = errm; inv_on = inv;
        done_cnt = 0; serr_cnt = 0; k = 0; aborted = 1'b0; hooked = 1'b0;
        repeat (20) sym();
        if (start_with_en) begin
            clk1(1'b1, 1'b1);
            repeat (3) clk1(1'b0, 1'b0);
        end else begin
            clk1(1'b0, 1'b1);
        end
        while (m_state != 3 && !aborted && k < 3000) begin
            if (hook == 1 && m_state == 2 && n_en - meas_start == 100) begin
                reset = 1'b1;
                clk1(1'b0, 1'b0);
                reset = 1'b0;
                aborted = 1'b1;
            end else begin
                if (hook == 2 && m_state == 2 && n_en - meas_start == 50 && !hooked) begin
                    clk1(1'b0, 1'b1);
                    hooked = 1'b1;
                end
                sym();
                k++;
            end
        end
        if (k >= 3000) chk({nm, "_timeout"}, 1, 0);
        if (aborted) begin
            chk({nm, "_rst_state"}, longint'(state), 0);
            chk({nm, "_rst_locked"}, longint'(locked), 0);
            chk({nm, "_rst_delay"}, longint'(delay_sel), 0);
            chk({nm, "_rst_errc"}, longint'(err_count), 0);
            chk({nm, "_rst_sq"}, longint'(sq_err_sum), 0);
            chk({nm, "_rst_symerr"}, longint'(sym_error | sym_correct | meas_done | align_fail), 0);
        end else begin
            repeat (8) clk1(1'b0, 1'b0);
            chk({nm, "_state"}, longint'(state), 3);
            chk({nm, "_delay"}, longint'(delay_sel), longint'(exp_delay));
            chk({nm, "_locked"}, longint'(locked), longint'(exp_lock));
            chk({nm, "_fail"}, longint'(align_fail), longint'(exp_fail));
            chk({nm, "_errc"}, longint'(err_count), longint'(exp_errc));
            chk({nm, "_done_pulses"}, longint'(done_cnt), longint'(exp_done));
            chk({nm, "_symerr_pulses"}, longint'(serr_cnt), longint'(exp_serr));
            if (exp_sq >= 0) chk({nm, "_sq"}, longint'(sq_err_sum), exp_sq);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sym_clk_en = 1'b0;
        tx_sym = '0; rx_sym = '0; err_in = '0;
        rx_mode = 0; err_mode = 0; inv_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset  = 1'b0;
        chk("reset_state", longint'(state), 0);
        chk("reset_outputs", longint'(locked | align_fail | meas_done | sym_error | sym_correct), 0);
        chk("reset_counts", longint'(err_count) + longint'(sq_err_sum) + longint'(delay_sel), 0);

        run_test("aligned", 0, 0, 1'b0, 1'b1, 0, 5, 1'b1, 1'b0, 0, 1, 0, 0);
        run_test("inverted3", 0, 2, 1'b1, 1'b0, 0, 5, 1'b1, 1'b0, 3, 1, 3, -1);
        run_test("rx_zero", 1, 0, 1'b0, 1'b0, 0, 15, 1'b0, 1'b1, 0, 0, 0, 0);
        run_test("err_m3", 0, 1, 1'b0, 1'b0, 0, 5, 1'b1, 1'b0, 0, 1, 0, SQ_EN ? 2304 : 0);
        run_test("rst_meas", 0, 0, 1'b0, 1'b0, 1, 5, 1'b1, 1'b0, 0, 1, 0, 0);
        run_test("realign", 0, 0, 1'b0, 1'b0, 0, 5, 1'b1, 1'b0, 0, 1, 0, 0);
        run_test("start_ign", 0, 2, 1'b0, 1'b0, 2, 5, 1'b1, 1'b0, 0, 1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
